pc_sequencer: RTL and testbench

Registered program-counter sequencer for the BitEpicness pipeline. It owns the 13-bit fetch PC and arbitrates among sequential fetch, jump, jump-register and branch redirects. It also handles hazard stalls and instruction-memory wait states, and produces the per-stage squash masks REG_Mask, EX_Mask and MEM_Mask. It sits between the ID/EX control outputs and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_sequencer_branch_resolve.sv | 30 +++
 rtl/pc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC sequencer: branch condition codes,
// sequencer state encoding and default datapath widths.
package pc_pkg;

    localparam int PC_WIDTH_DEFAULT   = 13;
    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_type_e;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_HOLD     = 3'd2,
        ST_FLUSH_BR = 3'd3,
        ST_FLUSH_J  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch condition evaluation from the EX-stage subtraction
// result (rs - rt) and its overflow flag.
module branch_resolve
    import pc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [1:0]            i_branch_type,
    input  logic [DATA_WIDTH-1:0] i_alu_output,
    input  logic                  i_alu_overflow,
    output logic                  o_taken
);

    logic w_zero;
    logic w_lt;

    assign w_zero = (i_alu_output == '0);
    // Sign of the true difference: result MSB corrected by overflow.
    assign w_lt   = i_alu_output[DATA_WIDTH-1] ^ i_alu_overflow;

    always_comb begin
        case (br_type_e'(i_branch_type))
            BR_EQ:   o_taken = w_zero;
            BR_NE:   o_taken = !w_zero;
            BR_LT:   o_taken = w_lt;
            default: o_taken = !w_lt;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch PC sequencer: reset drain, sequential fetch, jump / jump-register /
// branch redirects, stall and wait-state holds, and per-stage squash masks.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// INIT     | pipeline drain after reset, pc=RESET_PC, all masks set
// RUN      | live sequential fetch
// HOLD     | pc frozen for stall (EX bubble) and/or imem wait (IF/ID squash)
// FLUSH_BR | first cycle at a taken-branch target, IF/ID and ID/EX squashed
// FLUSH_J  | first cycle at a jump target, IF/ID squashed
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int                  DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  INIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  imem_ready,
    input  logic                  Jump,
    input  logic [PC_WIDTH-1:0]   JumpTarget,
    input  logic                  JumpRegister,
    input  logic [PC_WIDTH-1:0]   JumpRegisterTarget,
    input  logic                  Branch,
    input  logic [1:0]            BranchType,
    input  logic [DATA_WIDTH-1:0] ALUOutput,
    input  logic                  ALUOverflow,
    input  logic [PC_WIDTH-1:0]   BranchTarget,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  pc_valid,
    output logic                  redirect,
    output logic                  REG_Mask,
    output logic                  EX_Mask,
    output logic                  MEM_Mask
);

    localparam int CNT_W = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_pc_valid;
    logic                w_pc_valid_nxt;
    logic                r_redirect;
    logic                w_redirect_nxt;
    logic                r_reg_mask;
    logic                w_reg_mask_nxt;
    logic                r_ex_mask;
    logic                w_ex_mask_nxt;
    logic                r_mem_mask;
    logic                w_mem_mask_nxt;

    logic                w_cond_taken;
    logic                w_br_taken;
    logic                w_can_hold;
    logic                w_jump_ok;

    branch_resolve #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_branch_resolve (
        .i_branch_type  (BranchType),
        .i_alu_output   (ALUOutput),
        .i_alu_overflow (ALUOverflow),
        .o_taken        (w_cond_taken)
    );

    assign w_br_taken = Branch & w_cond_taken;
    assign w_can_hold = (r_state == ST_RUN) || (r_state == ST_HOLD);
    // A stalled ID instruction is frozen, so its jump must wait; during a
    // flush the ID instruction is wrong-path and its jump is dropped.
    assign w_jump_ok  = (r_state == ST_RUN) || ((r_state == ST_HOLD) && !stall);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_pc_valid_nxt = 1'b1;
        w_redirect_nxt = 1'b0;
        w_reg_mask_nxt = 1'b0;
        w_ex_mask_nxt  = 1'b0;
        w_mem_mask_nxt = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt      = r_cnt - 1'b1;
                    w_pc_valid_nxt = 1'b0;
                    w_reg_mask_nxt = 1'b1;
                    w_ex_mask_nxt  = 1'b1;
                    w_mem_mask_nxt = 1'b1;
                end
            end
            ST_RUN, ST_HOLD, ST_FLUSH_BR, ST_FLUSH_J: begin
                if (w_br_taken) begin
                    w_state_nxt    = ST_FLUSH_BR;
                    w_pc_nxt       = BranchTarget;
                    w_redirect_nxt = 1'b1;
                    w_reg_mask_nxt = 1'b1;
                    w_ex_mask_nxt  = 1'b1;
                end else if (w_jump_ok && (JumpRegister || Jump)) begin
                    w_state_nxt    = ST_FLUSH_J;
                    w_pc_nxt       = JumpRegister ? JumpRegisterTarget : JumpTarget;
                    w_redirect_nxt = 1'b1;
                    w_reg_mask_nxt = 1'b1;
                end else if (w_can_hold && (stall || !imem_ready)) begin
                    w_state_nxt    = ST_HOLD;
                    w_ex_mask_nxt  = stall;
                    w_reg_mask_nxt = !imem_ready;
                end else begin
                    // The current fetch completes only with data present and no stall.
                    w_state_nxt = ST_RUN;
                    if (!stall && imem_ready) begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_INIT;
                w_pc_nxt       = RESET_PC;
                w_cnt_nxt      = CNT_W'(INIT_CYCLES - 1);
                w_pc_valid_nxt = 1'b0;
                w_reg_mask_nxt = 1'b1;
                w_ex_mask_nxt  = 1'b1;
                w_mem_mask_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_pc       <= RESET_PC;
            r_cnt      <= CNT_W'(INIT_CYCLES - 1);
            r_pc_valid <= 1'b0;
            r_redirect <= 1'b0;
            r_reg_mask <= 1'b1;
            r_ex_mask  <= 1'b1;
            r_mem_mask <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_redirect <= w_redirect_nxt;
            r_reg_mask <= w_reg_mask_nxt;
            r_ex_mask  <= w_ex_mask_nxt;
            r_mem_mask <= w_mem_mask_nxt;
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign redirect = r_redirect;
    assign REG_Mask = r_reg_mask;
    assign EX_Mask  = r_ex_mask;
    assign MEM_Mask = r_mem_mask;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer, checked cycle by cycle
// against a behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;

    localparam int PC_W     = 13;
    localparam int DATA_W   = 16;
    localparam int RST_PC   = 0;
    localparam int INIT_CYC = 3;
    localparam int PC_MOD   = 1 << PC_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              imem_ready;
    logic              Jump;
    logic [PC_W-1:0]   JumpTarget;
    logic              JumpRegister;
    logic [PC_W-1:0]   JumpRegisterTarget;
    logic              Branch;
    logic [1:0]        BranchType;
    logic [DATA_W-1:0] ALUOutput;
    logic              ALUOverflow;
    logic [PC_W-1:0]   BranchTarget;
    logic [PC_W-1:0]   pc;
    logic              pc_valid;
    logic              redirect;
    logic              REG_Mask;
    logic              EX_Mask;
    logic              MEM_Mask;

    int total = 0;
    int bad   = 0;

    // model: pc, cycles left in reset drain, and how the last cycle ended
    // (0 = fetching, 1 = held, 2 = just redirected)
    int m_pc        = RST_PC;
    int m_init_left = INIT_CYC;
    int m_kind      = 0;
    bit e_valid, e_redir, e_reg, e_ex, e_mem;

    pc_sequencer #(
        .PC_WIDTH    (PC_W),
        .DATA_WIDTH  (DATA_W),
        .RESET_PC    (13'(RST_PC)),
        .INIT_CYCLES (INIT_CYC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .imem_ready         (imem_ready),
        .Jump               (Jump),
        .JumpTarget         (JumpTarget),
        .JumpRegister       (JumpRegister),
        .JumpRegisterTarget (JumpRegisterTarget),
        .Branch             (Branch),
        .BranchType         (BranchType),
        .ALUOutput          (ALUOutput),
        .ALUOverflow        (ALUOverflow),
        .BranchTarget       (BranchTarget),
        .pc                 (pc),
        .pc_valid           (pc_valid),
        .redirect           (redirect),
        .REG_Mask           (REG_Mask),
        .EX_Mask            (EX_Mask),
        .MEM_Mask           (MEM_Mask)
    );

    always #5 clk = ~clk;

    function automatic bit ref_taken(input logic [1:0] bt, input logic [DATA_W-1:0] d, input logic ovf);
        bit neg_true;
        neg_true = (($signed(d) < 0) != ovf);
        case (bt)
            2'd0:    return d == 0;
            2'd1:    return d != 0;
            2'd2:    return neg_true;
            default: return !neg_true;
        endcase
    endfunction

    task automatic model_edge();
        bit tk;
        bit can_jump;
        tk = Branch && ref_taken(BranchType, ALUOutput, ALUOverflow);
        e_redir = 0; e_reg = 0; e_ex = 0; e_mem = 0; e_valid = 1;
        if (reset) begin
            m_init_left = INIT_CYC;
            m_pc = RST_PC;
            m_kind = 0;
            e_valid = 0; e_reg = 1; e_ex = 1; e_mem = 1;
        end else if (m_init_left > 0) begin
            m_init_left--;
            m_kind = 0;
            if (m_init_left > 0) begin
                e_valid = 0; e_reg = 1; e_ex = 1; e_mem = 1;
            end
        end else begin
            can_jump = (m_kind == 0) || (m_kind == 1 && !stall);
            if (tk) begin
                m_pc = int'(BranchTarget);
                e_redir = 1; e_reg = 1; e_ex = 1;
                m_kind = 2;
            end else if (can_jump && (JumpRegister || Jump)) begin
                m_pc = JumpRegister ? int'(JumpRegisterTarget) : int'(JumpTarget);
                e_redir = 1; e_reg = 1;
                m_kind = 2;
            end else if (m_kind != 2 && (stall || !imem_ready)) begin
                e_ex = stall; e_reg = !imem_ready;
                m_kind = 1;
            end else begin
                if (!stall && imem_ready) m_pc = (m_pc + 1) % PC_MOD;
                m_kind = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("pc",       32'(pc),       32'(m_pc));
        chk("pc_valid", 32'(pc_valid), 32'(e_valid));
        chk("redirect", 32'(redirect), 32'(e_redir));
        chk("REG_Mask", 32'(REG_Mask), 32'(e_reg));
        chk("EX_Mask",  32'(EX_Mask),  32'(e_ex));
        chk("MEM_Mask", 32'(MEM_Mask), 32'(e_mem));
    endtask

    task automatic idle_inputs();
        stall = 0; imem_ready = 1; Jump = 0; JumpRegister = 0; Branch = 0;
        JumpTarget = '0; JumpRegisterTarget = '0; BranchTarget = '0;
        BranchType = 2'b00; ALUOutput = 16'h0001; ALUOverflow = 0;
    endtask

    task automatic masks_are(input string tag, input logic [2:0] m);
        chk(tag, {29'd0, REG_Mask, EX_Mask, MEM_Mask}, {29'd0, m});
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        chk("rst_pc", 32'(pc), 32'(RST_PC));
        chk("rst_valid", 32'(pc_valid), 0);
        masks_are("rst_masks", 3'b111);
        reset = 0;

        tick(); chk("drain1_valid", 32'(pc_valid), 0); masks_are("drain1_masks", 3'b111);
        tick(); chk("drain2_valid", 32'(pc_valid), 0);
        tick(); chk("first_fetch_valid", 32'(pc_valid), 1); chk("first_fetch_pc", 32'(pc), 0);
        masks_are("first_fetch_masks", 3'b000);
        tick(); chk("seq_pc1", 32'(pc), 1);
        tick(); chk("seq_pc2", 32'(pc), 2);

        Jump = 1; JumpTarget = 13'd16;
        tick(); chk("jump_pc", 32'(pc), 16); chk("jump_redirect", 32'(redirect), 1);
        masks_are("jump_masks", 3'b100);
        Jump = 0;
        tick(); chk("after_jump_pc", 32'(pc), 17);

        Branch = 1; BranchType = 2'b01; ALUOutput = 16'd0; ALUOverflow = 1; BranchTarget = 13'd5;
        tick(); chk("ne_not_taken_pc", 32'(pc), 18); masks_are("ne_not_taken_masks", 3'b000);
        BranchType = 2'b10;
        tick(); chk("lt_taken_pc", 32'(pc), 5); chk("lt_taken_redirect", 32'(redirect), 1);
        masks_are("lt_taken_masks", 3'b110);
        Branch = 0;
        tick();

        Branch = 1; BranchType = 2'b10; ALUOutput = 16'd0; ALUOverflow = 1; BranchTarget = 13'd5;
        JumpRegister = 1; JumpRegisterTarget = 13'd40; Jump = 1; JumpTarget = 13'd60;
        tick(); chk("prio_pc", 32'(pc), 5); masks_are("prio_masks", 3'b110);
        idle_inputs();
        tick();

        Jump = 1; JumpTarget = 13'd29;
        tick(); Jump = 0;
        tick(); chk("at30_pc", 32'(pc), 30);
        stall = 1;
        tick(); chk("stall1_pc", 32'(pc), 30); masks_are("stall1_masks", 3'b010);
        tick(); chk("stall2_pc", 32'(pc), 30); masks_are("stall2_masks", 3'b010);
        stall = 0;
        tick(); chk("stall_exit_pc", 32'(pc), 31);
        imem_ready = 0;
        tick(); chk("wait1_pc", 32'(pc), 31); masks_are("wait1_masks", 3'b100);
        tick(); chk("wait2_pc", 32'(pc), 31);
        imem_ready = 1;
        tick(); chk("wait_exit_pc", 32'(pc), 32);

        JumpRegister = 1; JumpRegisterTarget = 13'd8190;
        tick(); JumpRegister = 0;
        tick(); chk("pc_max", 32'(pc), 8191);
        tick(); chk("pc_wrap", 32'(pc), 0);
        stall = 1;
        tick();
        Jump = 1; JumpTarget = 13'd8191;
        tick(); chk("hold_jump_ignored_pc", 32'(pc), 0); chk("hold_jump_no_redirect", 32'(redirect), 0);
        idle_inputs();
        tick();

        Branch = 1; BranchType = 2'b10; ALUOutput = 16'h8000; ALUOverflow = 0; BranchTarget = 13'd77;
        reset = 1;
        tick(); chk("rst_vs_branch_pc", 32'(pc), 32'(RST_PC)); chk("rst_vs_branch_valid", 32'(pc_valid), 0);
        masks_are("rst_vs_branch_masks", 3'b111);
        reset = 0; idle_inputs();

        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(199) == 0);
            stall              = ($urandom_range(4) == 0);
            imem_ready         = ($urandom_range(4) != 0);
            Jump               = ($urandom_range(6) == 0);
            JumpRegister       = ($urandom_range(9) == 0);
            Branch             = ($urandom_range(4) == 0);
            BranchType         = 2'($urandom_range(3));
            ALUOutput          = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom);
            ALUOverflow        = 1'($urandom_range(1));
            JumpTarget         = 13'($urandom);
            JumpRegisterTarget = 13'($urandom);
            BranchTarget       = ($urandom_range(7) == 0) ? 13'd8191 : 13'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
